// File: rtl/avmm_pkg.sv
// Shared types for the wait-state Avalon-MM memory: read FSM states and bus constants.
package avmm_pkg;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } avmm_state_e;

endpackage

// File: rtl/avmm_be_ram.sv
// Byte-enabled word array: synchronous write, asynchronous read, contents never reset.
module avmm_be_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [IDX_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [IDX_W-1:0]    i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/avmm_wait_mem.sv
// Avalon-MM slave memory with fixed read wait states, zero-wait byte writes and a sticky error flag.
// Define AVMM_WAIT_MEM_SHIFT_EN to return read data left-shifted by SHIFT.
module avmm_wait_mem
    import avmm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1,
    parameter int SHIFT       = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_waitrequest,
    output logic                err,
    output avmm_state_e         o_dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_CYCLES >= 2) ? CNT_W'(WAIT_CYCLES - 2) : '0;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    if (SHIFT < 0 || SHIFT >= DATA_W) begin : g_bad_shift
        $error("avmm_wait_mem: SHIFT out of range");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
        $error("avmm_wait_mem: WAIT_CYCLES out of range");
    end

    avmm_state_e       r_state;
    avmm_state_e       w_nxt_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [DATA_W-1:0] r_readdata;
    logic              r_err;

    logic              w_in_range;
    logic              w_rd_load;
    logic              w_mem_we;
    logic              w_err_set;
    logic              w_waitrequest;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_word_sh;

    // Handshake: a read is accepted in the single cycle where s0_read is high and
    // s0_waitrequest is low (the DONE cycle); writes never stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (s0_read) begin
                    if (WAIT_CYCLES == 1) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_state = ST_WAIT;
                        w_nxt_cnt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!s0_read) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: w_nxt_state = ST_IDLE;
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_waitrequest = s0_read && (r_state != ST_DONE);
        w_in_range    = (s0_address < DEPTH_A);
        w_rd_load     = (w_nxt_state == ST_DONE) && (r_state != ST_DONE);
        // Memory has no reset, so writes are blocked explicitly while reset is held.
        w_mem_we      = reset && (r_state == ST_IDLE) && s0_write && !s0_read && w_in_range;
        w_err_set     = (s0_write && (s0_read || (r_state != ST_IDLE) || !w_in_range))
                     || (w_rd_load && !w_in_range);
    end

    assign w_idx = s0_address[IDX_W-1:0];

    avmm_be_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_be    (s0_byteenable),
        .i_waddr (w_idx),
        .i_wdata (s0_writedata),
        .i_raddr (w_idx),
        .o_rdata (w_rd_word)
    );

`ifdef AVMM_WAIT_MEM_SHIFT_EN
    assign w_rd_word_sh = w_rd_word << SHIFT;
`else
    assign w_rd_word_sh = w_rd_word;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_rd_load) begin
                r_readdata <= w_in_range ? w_rd_word_sh : '0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s0_readdata    = r_readdata;
    assign s0_waitrequest = w_waitrequest;
    assign err            = r_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_avmm_wait_mem.sv
// Randomized and directed bench for avmm_wait_mem against a byte-array memory model.
module tb_avmm_wait_mem;
    import avmm_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 128;
    localparam int TB_WAIT = 4;
    localparam int SHIFT   = 1;
    localparam int NB      = DATA_W / 8;

    logic              clk;
    logic              reset;
    logic [31:0]       s0_address;
    logic              s0_read;
    logic              s0_write;
    logic [NB-1:0]     s0_byteenable;
    logic [DATA_W-1:0] s0_writedata;
    logic [DATA_W-1:0] s0_readdata;
    logic              s0_waitrequest;
    logic              err;
    avmm_state_e       o_dbg_state;

    avmm_wait_mem #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (TB_WAIT),
        .SHIFT       (SHIFT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s0_address     (s0_address),
        .s0_read        (s0_read),
        .s0_write       (s0_write),
        .s0_byteenable  (s0_byteenable),
        .s0_writedata   (s0_writedata),
        .s0_readdata    (s0_readdata),
        .s0_waitrequest (s0_waitrequest),
        .err            (err),
        .o_dbg_state    (o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // reference model
    logic [7:0]        m_bytes [DEPTH][NB];
    bit                m_err;
    logic [DATA_W-1:0] last_rd;
    int                vectors;
    int                miscompares;

    function automatic logic [DATA_W-1:0] model_word(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        if (a >= DEPTH) return '0;
        w = '0;
        for (int b = 0; b < NB; b++) w[b*8 +: 8] = m_bytes[a][b];
`ifdef AVMM_WAIT_MEM_SHIFT_EN
        return w << SHIFT;
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic do_write(input logic [31:0] a, input logic [NB-1:0] be, input logic [DATA_W-1:0] d);
        @(negedge clk);
        s0_address = a; s0_byteenable = be; s0_writedata = d;
        s0_write = 1'b1; s0_read = 1'b0;
        #1 check("wr_waitrequest", DATA_W'(s0_waitrequest), '0);
        @(negedge clk);
        s0_write = 1'b0;
        if (a < DEPTH) begin
            for (int b = 0; b < NB; b++) if (be[b]) m_bytes[a][b] = d[b*8 +: 8];
        end else begin
            m_err = 1'b1;
        end
        check("wr_err", DATA_W'(err), DATA_W'(m_err));
    endtask

    // Full read; with_wr also raises s0_write in the first request cycle.
    task automatic do_read(input logic [31:0] a, input bit with_wr);
        logic [DATA_W-1:0] exp;
        int waits;
        bit done;
        exp = model_word(a);
        if (a >= DEPTH || with_wr) m_err = 1'b1;
        @(negedge clk);
        s0_address = a; s0_read = 1'b1; s0_write = with_wr;
        s0_writedata = ~exp; s0_byteenable = '1;
        waits = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!s0_waitrequest) begin
                done = 1'b1;
            end else begin
                waits++;
                @(negedge clk);
                s0_write = 1'b0;
            end
        end
        check("rd_done", DATA_W'(done), DATA_W'(1));
        check("rd_waits", DATA_W'(waits), DATA_W'(TB_WAIT));
        check("rd_data", s0_readdata, exp);
        last_rd = exp;
        @(negedge clk);
        s0_read = 1'b0; s0_write = 1'b0;
        check("rd_err", DATA_W'(err), DATA_W'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_readdata", s0_readdata, '0);
        check("rst_err", DATA_W'(err), '0);
        m_err = 1'b0; last_rd = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0]       addr;
    logic [DATA_W-1:0] exp_const;

    initial begin
        vectors = 0; miscompares = 0; m_err = 1'b0; last_rd = '0;
        reset = 1'b0; s0_address = '0; s0_read = 1'b0; s0_write = 1'b0;
        s0_byteenable = '0; s0_writedata = '0;

        // reset state
        #22;
        check("reset_readdata", s0_readdata, '0);
        check("reset_err", DATA_W'(err), '0);
        check("reset_state", DATA_W'(o_dbg_state), DATA_W'(ST_IDLE));
        check("reset_wr_idle", DATA_W'(s0_waitrequest), '0);
        s0_read = 1'b1;
        #1 check("reset_wr_read", DATA_W'(s0_waitrequest), DATA_W'(1));
        s0_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_write(i, '1, $urandom);

        // word write then read back
        do_write(3, '1, 32'h0000_0005);
        do_read(3, 1'b0);

        // partial byte-lane update
        do_write(10, '1, 32'hAABB_CCDD);
        do_write(10, 4'b0010, 32'h0000_1100);
        exp_const = 32'hAABB_11DD;
`ifdef AVMM_WAIT_MEM_SHIFT_EN
        exp_const = exp_const << SHIFT;
`endif
        do_read(10, 1'b0);
        check("be_merge_const", s0_readdata, exp_const);

        // random in-range traffic, err must stay clear
        for (int i = 0; i < 30; i++) begin
            addr = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 0) do_write(addr, NB'($urandom_range(0, 15)), $urandom);
            else do_read(addr, 1'b0);
        end

        // read abandoned in WAIT
        @(negedge clk);
        s0_address = 40; s0_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s0_read = 1'b0;
        @(negedge clk);
        #1;
        check("abandon_state", DATA_W'(o_dbg_state), DATA_W'(ST_IDLE));
        check("abandon_readdata", s0_readdata, last_rd);
        check("abandon_err", DATA_W'(err), '0);

        // read and write together: read wins, write dropped
        do_read(5, 1'b1);
        do_read(5, 1'b0);

        // reset in the middle of a read
        do_reset();
        do_read(60, 1'b0);
        @(negedge clk);
        s0_address = 61; s0_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_readdata", s0_readdata, '0);
        check("midrst_state", DATA_W'(o_dbg_state), DATA_W'(ST_IDLE));
        check("midrst_err", DATA_W'(err), '0);
        check("midrst_waitreq", DATA_W'(s0_waitrequest), DATA_W'(1));
        m_err = 1'b0; last_rd = '0;
        @(negedge clk);
        s0_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_read(61, 1'b0);
        do_read(60, 1'b0);

        // write during WAIT is dropped and flagged
        @(negedge clk);
        s0_address = 20; s0_read = 1'b1;
        @(negedge clk);
        s0_write = 1'b1; s0_byteenable = '1; s0_writedata = ~model_word(20);
        m_err = 1'b1;
        @(negedge clk);
        s0_write = 1'b0; s0_read = 1'b0;
        @(negedge clk);
        do_read(20, 1'b0);

        // out-of-range access
        do_reset();
        do_read(200, 1'b0);
        do_write(7, '1, 32'h1234_5678);
        do_read(7, 1'b0);
        do_write(DEPTH, '1, 32'hDEAD_BEEF);
        do_read(0, 1'b0);

        // random mixed traffic including out-of-range addresses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) addr = $urandom_range(DEPTH, 300);
            else addr = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 0) do_write(addr, NB'($urandom_range(0, 15)), $urandom);
            else do_read(addr, 1'b0);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
